uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller between the bus register file and uart_rx. Gates rx_en, tracks frame progress,
//  buffers completed bytes in a DEPTH-entry FIFO, and raises watermark, idle-timeout, overflow and
//  false-start-abort interrupts. uart_rx stays a pure bit-level datapath; this block owns sequencing.
// PARAMETERS
//  DEPTH    16  FIFO entries; power of 2, >=2
//  LVL_W    $clog2(DEPTH)+1  width of level/watermark fields (derived, do not override)
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      asynchronous active-low reset
//  enable_i       in   1      software receive enable
//  clks_per_bit_i in   16     baud divisor, same value driven to uart_rx
//  watermark_i    in   LVL_W  irq_wm_o asserts when level >= watermark_i (0 disables)
//  timeout_bits_i in   8      idle bit-times before irq_to_o (0 disables)
//  flush_i        in   1      1-cycle pulse: empty FIFO
//  clr_status_i   in   1      1-cycle pulse: clear all sticky flags/irqs
//  rx_start_i     in   1      uart_rx start-phase indicator (c_START)
//  rx_done_i      in   1      uart_rx 1-cycle byte-complete strobe
//  rx_data_i      in   8      uart_rx received byte, valid with rx_done_i
//  rx_en_o        out  1      enable to uart_rx
//  rd_req_i       in   1      pop request
//  rd_data_o      out  8      popped byte
//  rd_valid_o     out  1      1-cycle strobe, rd_data_o valid
//  level_o        out  LVL_W  FIFO occupancy
//  empty_o/full_o out  1      level==0 / level==DEPTH
//  busy_o         out  1      state==BUSY
//  irq_wm_o       out  1      level-sensitive watermark irq
//  irq_to_o       out  1      sticky idle-timeout irq
//  irq_ovf_o      out  1      sticky overflow irq (byte dropped)
//  irq_abort_o    out  1      sticky false-start/stuck-frame irq
// BEHAVIOUR
//  Reset: state OFF; FIFO empty; all outputs 0 except empty_o=1; rd_data_o=8'h00.
//  FSM: OFF  -> IDLE when enable_i; rx_en_o=0 in OFF, 1 in IDLE/BUSY/DRAIN.
//       IDLE -> BUSY on rx_start_i rising edge; -> OFF when !enable_i.
//       BUSY -> IDLE (or DRAIN->OFF path if !enable_i) on rx_done_i; frame watchdog counts bit-times
//               (bit tick = every clks_per_bit_i clocks); at 10 bit-times without rx_done_i -> IDLE,
//               set irq_abort_o. Deasserting enable_i in BUSY -> DRAIN (frame not cut).
//       DRAIN-> OFF on rx_done_i or watchdog expiry (watchdog sets irq_abort_o); rx_en_o held 1.
//  rx_done_i outside BUSY/DRAIN still pushes (uart_rx is authoritative); never ignored.
//  Push: rx_done_i && !full -> write rx_data_i, level+1 next cycle. rx_done_i && full && !pop ->
//        byte dropped, irq_ovf_o set. Full + push + pop same cycle: both succeed, level unchanged.
//  Pop: rd_req_i && !empty -> rd_data_o=head, rd_valid_o=1 the next cycle (latency 1). Pop on empty:
//       ignored, rd_valid_o=0, rd_data_o holds last value. Pop+push on empty: push only.
//  Pointers: LVL_W-1 bits, wrap modulo DEPTH; level = separate counter, never exceeds DEPTH.
//  flush_i: pointers/level to 0 next cycle; overrides same-cycle push and pop (both discarded,
//           no rd_valid_o). Does not change FSM state or sticky flags.
//  Timeout: counter runs in IDLE while !empty && timeout_bits_i!=0; counts bit ticks; clears on push,
//           pop or entry to BUSY; at timeout_bits_i ticks sets irq_to_o once (not re-armed until cleared).
//  irq_wm_o = (watermark_i!=0) && (level_o >= watermark_i), combinational from registered level.
//  clr_status_i clears irq_to/ovf/abort; a same-cycle setting event wins (flag stays 1).
//  clks_per_bit_i 0 or 1 treated as 1 (bit tick every cycle). Changes take effect at next bit tick.
//  No reset mid-operation beyond rst_ni: async assertion returns everything to reset values at once.
// TESTING
//  Enable, 3 frames 0x55,0xA3,0x00 via uart_rx model -> level 3, pops return 55,A3,00 each 1 cycle later.
//  DEPTH=16, 17 bytes no pops -> full_o=1, irq_ovf_o=1, pops yield first 16 bytes; clr_status_i clears.
//  Full FIFO, rx_done_i and rd_req_i same cycle -> level stays 16, head out, new byte at tail.
//  Glitch start (rx_start_i high, no rx_done_i), clks_per_bit=8 -> 80 cycles later IDLE, irq_abort_o=1.
//  enable_i dropped mid-frame -> rx_en_o stays 1 until rx_done_i, byte pushed, then OFF/rx_en_o=0.
//  timeout_bits=4, clks_per_bit=10, 1 byte -> irq_to_o at 40 cycles idle; flush_i -> empty, irq held.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencing for uart_rx: enable gating, frame watchdog, byte FIFO and interrupts.
// The bit-level datapath stays in uart_rx; this block only decides when it runs and what happens to its bytes.
//
// state | meaning
// OFF   | receiver disabled, rx_en_o low
// IDLE  | enabled, waiting for a start bit; idle timeout may run
// BUSY  | frame in progress, watchdog counting bit-times
// DRAIN | enable dropped mid-frame; finish the frame, then OFF
module uart_rx_ctrl #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [15:0]      clks_per_bit_i,
    input  logic [LVL_W-1:0] watermark_i,
    input  logic [7:0]       timeout_bits_i,
    input  logic             flush_i,
    input  logic             clr_status_i,
    input  logic             rx_start_i,
    input  logic             rx_done_i,
    input  logic [7:0]       rx_data_i,
    output logic             rx_en_o,
    input  logic             rd_req_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic [LVL_W-1:0] level_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             busy_o,
    output logic             irq_wm_o,
    output logic             irq_to_o,
    output logic             irq_ovf_o,
    output logic             irq_abort_o
);

    localparam int PTR_W = LVL_W - 1;

    typedef enum logic [1:0] {S_OFF, S_IDLE, S_BUSY, S_DRAIN} state_t;

    state_t           state, state_nxt;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push_ok, pop_ok, drop;
    logic             start_q, start_rise;
    logic [15:0]      div_cnt, div_load;
    logic             tick, restart;
    logic [3:0]       wd_cnt;
    logic             in_frame, wd_expire, enter_busy, enter_idle;
    logic [7:0]       to_cnt;
    logic             to_active, to_set;

    assign level_o  = level;
    assign empty_o  = (level == '0);
    assign full_o   = (level == LVL_W'(DEPTH));
    assign irq_wm_o = (watermark_i != '0) && (level >= watermark_i);

    // Flush swallows both sides of the FIFO for the cycle it is asserted.
    assign pop_ok  = rd_req_i && !empty_o && !flush_i;
    assign push_ok = rx_done_i && !flush_i && (!full_o || pop_ok);
    assign drop    = rx_done_i && !flush_i && full_o && !pop_ok;

    assign start_rise = rx_start_i && !start_q;
    assign div_load   = (clks_per_bit_i <= 16'd1) ? 16'd0 : clks_per_bit_i - 16'd1;
    assign tick       = (div_cnt == 16'd0);
    assign in_frame   = (state == S_BUSY) || (state == S_DRAIN);
    assign wd_expire  = in_frame && tick && (wd_cnt == 4'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:   if (enable_i) state_nxt = S_IDLE;
            S_IDLE:  begin
                if (!enable_i)       state_nxt = S_OFF;
                else if (start_rise) state_nxt = S_BUSY;
            end
            S_BUSY:  begin
                if (rx_done_i || wd_expire) state_nxt = enable_i ? S_IDLE : S_OFF;
                else if (!enable_i)         state_nxt = S_DRAIN;
            end
            S_DRAIN: if (rx_done_i || wd_expire) state_nxt = S_OFF;
            default: state_nxt = S_OFF;
        endcase
    end

    assign enter_busy = (state == S_IDLE) && (state_nxt == S_BUSY);
    assign enter_idle = (state != S_IDLE) && (state_nxt == S_IDLE);
    // The shared divider is re-phased whenever a new interval starts; BUSY->DRAIN keeps the frame's phase.
    assign restart    = enter_busy || enter_idle || ((push_ok || pop_ok) && !in_frame);

    assign to_active = (state == S_IDLE) && !empty_o && (timeout_bits_i != 8'd0)
                       && tick && (to_cnt != 8'd0);
    assign to_set    = to_active && (to_cnt == 8'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_OFF;
            rx_en_o     <= 1'b0;
            busy_o      <= 1'b0;
            wd_cnt      <= 4'd0;
            irq_abort_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_en_o     <= (state_nxt != S_OFF);
            busy_o      <= (state_nxt == S_BUSY);
            irq_abort_o <= wd_expire || (irq_abort_o && !clr_status_i);
            if (enter_busy)
                wd_cnt <= 4'd10;
            else if (in_frame && tick && (wd_cnt != 4'd0))
                wd_cnt <= wd_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q   <= 1'b0;
            div_cnt   <= 16'd0;
            to_cnt    <= 8'd0;
            irq_to_o  <= 1'b0;
            irq_ovf_o <= 1'b0;
        end else begin
            start_q   <= rx_start_i;
            irq_to_o  <= to_set || (irq_to_o && !clr_status_i);
            irq_ovf_o <= drop || (irq_ovf_o && !clr_status_i);
            if (restart || tick)
                div_cnt <= div_load;
            else
                div_cnt <= div_cnt - 16'd1;
            // Counter parks at zero after firing so the irq is raised only once per idle stretch.
            if (restart)
                to_cnt <= timeout_bits_i;
            else if (to_active)
                to_cnt <= to_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_data_o  <= 8'h00;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= pop_ok;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok) begin
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                    rd_data_o <= mem[rd_ptr];
                end
                if (push_ok && !pop_ok)
                    level <= level + LVL_W'(1);
                else if (pop_ok && !push_ok)
                    level <= level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= rx_data_i;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a FIFO vector table plus hand-written sequences for
// framing, overflow, watchdog abort, drain-on-disable and idle timeout.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             enable_i;
    logic [15:0]      clks_per_bit_i;
    logic [LVL_W-1:0] watermark_i;
    logic [7:0]       timeout_bits_i;
    logic             flush_i;
    logic             clr_status_i;
    logic             rx_start_i;
    logic             rx_done_i;
    logic [7:0]       rx_data_i;
    logic             rx_en_o;
    logic             rd_req_i;
    logic [7:0]       rd_data_o;
    logic             rd_valid_o;
    logic [LVL_W-1:0] level_o;
    logic             empty_o;
    logic             full_o;
    logic             busy_o;
    logic             irq_wm_o;
    logic             irq_to_o;
    logic             irq_ovf_o;
    logic             irq_abort_o;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clks_per_bit_i(clks_per_bit_i),
        .watermark_i(watermark_i), .timeout_bits_i(timeout_bits_i), .flush_i(flush_i),
        .clr_status_i(clr_status_i), .rx_start_i(rx_start_i), .rx_done_i(rx_done_i),
        .rx_data_i(rx_data_i), .rx_en_o(rx_en_o), .rd_req_i(rd_req_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
        .busy_o(busy_o), .irq_wm_o(irq_wm_o), .irq_to_o(irq_to_o), .irq_ovf_o(irq_ovf_o),
        .irq_abort_o(irq_abort_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       push;
        logic [7:0] data;
        logic       pop;
        logic       flush;
        int         lvl;
        logic       vld;
        logic [7:0] rdd;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        enable_i = 1'b0;
        rx_start_i = 1'b0;
        rx_done_i = 1'b0;
        rd_req_i = 1'b0;
        flush_i = 1'b0;
        clr_status_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] b);
        rx_data_i = b;
        rx_done_i = 1'b1;
        tick();
        rx_done_i = 1'b0;
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        chk({nm, "_valid"}, rd_valid_o, 1);
        chk({nm, "_data"}, rd_data_o, exp);
    endtask

    // uart_rx stand-in with clks_per_bit=4: start phase of one bit, done 9.5 bit-times after the start edge.
    task automatic frame(input logic [7:0] b, input bit drop_en);
        rx_start_i = 1'b1;
        tick();
        chk("frame_busy", busy_o, 1);
        repeat (3) tick();
        rx_start_i = 1'b0;
        if (drop_en) begin
            enable_i = 1'b0;
            tick();
            chk("drain_rx_en", rx_en_o, 1);
            chk("drain_busy", busy_o, 0);
            repeat (33) tick();
        end else begin
            repeat (34) tick();
        end
        push(b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        clks_per_bit_i = 16'd4;
        watermark_i = '0;
        timeout_bits_i = 8'd0;
        rx_data_i = 8'h00;
        rst_ni = 1'b0;
        enable_i = 1'b0; rx_start_i = 1'b0; rx_done_i = 1'b0;
        rd_req_i = 1'b0; flush_i = 1'b0; clr_status_i = 1'b0;
        tick();
        tick();
        chk("rst_rx_en", rx_en_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_irqs", {busy_o, rd_valid_o, irq_wm_o, irq_to_o, irq_ovf_o, irq_abort_o}, 0);
        rst_ni = 1'b1;
        tick();

        vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 2, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h55};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'hA3};
        vecs[5]  = '{1'b1, 8'h7E, 1'b1, 1'b0, 1, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h7E};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h7E};
        vecs[9]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b0, 8'h7E};
        vecs[10] = '{1'b1, 8'h22, 1'b0, 1'b1, 0, 1'b0, 8'h7E};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h7E};
        vecs[12] = '{1'b1, 8'h44, 1'b0, 1'b0, 1, 1'b0, 8'h7E};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h7E};
        vecs[14] = '{1'b1, 8'h66, 1'b0, 1'b0, 1, 1'b0, 8'h7E};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h66};

        watermark_i = 5'd2;
        for (int i = 0; i < 16; i++) begin
            rx_done_i = vecs[i].push;
            rx_data_i = vecs[i].data;
            rd_req_i  = vecs[i].pop;
            flush_i   = vecs[i].flush;
            tick();
            rx_done_i = 1'b0; rd_req_i = 1'b0; flush_i = 1'b0;
            chk($sformatf("vec%0d_level", i), level_o, vecs[i].lvl);
            chk($sformatf("vec%0d_valid", i), rd_valid_o, vecs[i].vld);
            chk($sformatf("vec%0d_data", i), rd_data_o, vecs[i].rdd);
            chk($sformatf("vec%0d_empty", i), empty_o, (vecs[i].lvl == 0));
            chk($sformatf("vec%0d_wm", i), irq_wm_o, (vecs[i].lvl >= 2));
        end
        watermark_i = '0;

        // three framed bytes
        clks_per_bit_i = 16'd4;
        enable_i = 1'b1;
        tick();
        chk("en_rx_en", rx_en_o, 1);
        frame(8'h55, 1'b0);
        frame(8'hA3, 1'b0);
        frame(8'h00, 1'b0);
        chk("frames_level", level_o, 3);
        chk("frames_busy", busy_o, 0);
        chk("frames_abort", irq_abort_o, 0);
        chk("frames_rx_en", rx_en_o, 1);
        pop_chk("frame_pop0", 8'h55);
        pop_chk("frame_pop1", 8'hA3);
        pop_chk("frame_pop2", 8'h00);
        chk("frames_empty", empty_o, 1);

        // async reset mid-operation
        push(8'h99);
        rst_ni = 1'b0;
        #2;
        chk("async_rst_level", level_o, 0);
        chk("async_rst_rx_en", rx_en_o, 0);
        chk("async_rst_data", rd_data_o, 0);
        tick();
        rst_ni = 1'b1;

        // overflow, clear priority, full push+pop
        do_reset();
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        chk("full_full", full_o, 1);
        chk("full_level", level_o, 16);
        chk("full_ovf0", irq_ovf_o, 0);
        push(8'hEE);
        chk("ovf_set", irq_ovf_o, 1);
        chk("ovf_level", level_o, 16);
        clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
        chk("ovf_clr", irq_ovf_o, 0);
        clr_status_i = 1'b1; push(8'hEF); clr_status_i = 1'b0;
        chk("ovf_set_wins", irq_ovf_o, 1);
        clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
        rx_data_i = 8'hC5; rx_done_i = 1'b1; rd_req_i = 1'b1;
        tick();
        rx_done_i = 1'b0; rd_req_i = 1'b0;
        chk("fullpp_level", level_o, 16);
        chk("fullpp_valid", rd_valid_o, 1);
        chk("fullpp_data", rd_data_o, 8'h10);
        chk("fullpp_ovf", irq_ovf_o, 0);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("ovf_pop%0d", i), 8'h10 + 8'(i));
        pop_chk("ovf_pop_tail", 8'hC5);
        chk("ovf_empty", empty_o, 1);

        // glitch start: watchdog after 10 bit-times of 8 clocks
        do_reset();
        clks_per_bit_i = 16'd8;
        enable_i = 1'b1;
        tick();
        rx_start_i = 1'b1;
        tick();
        rx_start_i = 1'b0;
        chk("glitch_busy", busy_o, 1);
        n = 0;
        while (busy_o && n < 200) begin
            tick();
            n++;
        end
        chk("glitch_cycles", n, 80);
        chk("glitch_abort", irq_abort_o, 1);
        chk("glitch_rx_en", rx_en_o, 1);
        clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
        chk("abort_clr", irq_abort_o, 0);

        // enable dropped mid-frame
        do_reset();
        clks_per_bit_i = 16'd4;
        enable_i = 1'b1;
        tick();
        frame(8'h5A, 1'b1);
        chk("drain_off_rx_en", rx_en_o, 0);
        chk("drain_level", level_o, 1);
        chk("drain_abort", irq_abort_o, 0);
        pop_chk("drain_pop", 8'h5A);

        // idle timeout
        do_reset();
        clks_per_bit_i = 16'd10;
        timeout_bits_i = 8'd4;
        enable_i = 1'b1;
        tick();
        push(8'hC3);
        n = 0;
        while (!irq_to_o && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 40);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk("to_flush_empty", empty_o, 1);
        chk("to_flush_held", irq_to_o, 1);
        clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
        chk("to_clr", irq_to_o, 0);
        repeat (50) tick();
        chk("to_no_refire", irq_to_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
